// File: rtl/mem_pipe_sequencer.sv
// Arbitrates the single memory port between fetch (stage 1) and data (stage 4),
// generates pipeline holds, the post-LPC flush window and an access watchdog.
module mem_pipe_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_WAIT     = 15,
    parameter int WAIT_W       = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_req,
    input  logic data_req,
    input  logic data_wr,
    input  logic mem_ack,
    input  logic lpc_s3,
    output logic mem_req,
    output logic mem_sel,
    output logic mem_we,
    output logic fetch_done,
    output logic data_done,
    output logic hold_s1,
    output logic hold_s2,
    output logic hold_s3,
    output logic flush_s1,
    output logic flush_s2,
    output logic mem_err
);

    typedef enum logic [1:0] {IDLE, FETCH_BUSY, DATA_BUSY} state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        flush_cnt;
    logic              fetch_done_raw, data_done_q;
    logic              fetch_pend, data_pend, lpc_acc, busy, timeout, finish;

    // A requester keeps its request high through the done cycle, so pending
    // means "requested and not being completed right now".
    assign data_pend  = data_req & ~data_done;
    assign fetch_pend = fetch_req & ~fetch_done;
    assign hold_s3    = data_pend;
    assign hold_s2    = data_pend;
    assign hold_s1    = data_pend | fetch_pend;

    assign lpc_acc    = lpc_s3 & ~hold_s3;
    assign flush_s1   = (flush_cnt != 3'd0);
    assign flush_s2   = flush_s1;
    // A fetch finishing inside the flush window is discarded; fetch_pend then
    // stays high and the FSM re-serves it.
    assign fetch_done = fetch_done_raw & ~flush_s1 & ~lpc_acc;
    assign data_done  = data_done_q;

    assign busy    = (state != IDLE);
    assign timeout = busy & ~mem_ack & (wait_cnt == WAIT_W'(MAX_WAIT - 1));
    assign finish  = busy & (mem_ack | timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_pend)       state_next = DATA_BUSY;
                else if (fetch_pend) state_next = FETCH_BUSY;
            end
            FETCH_BUSY, DATA_BUSY: begin
                if (finish) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req        <= 1'b0;
            mem_sel        <= 1'b0;
            mem_we         <= 1'b0;
            wait_cnt       <= '0;
            fetch_done_raw <= 1'b0;
            data_done_q    <= 1'b0;
            mem_err        <= 1'b0;
            flush_cnt      <= 3'd0;
        end else begin
            mem_req        <= (state_next != IDLE);
            mem_sel        <= (state_next == DATA_BUSY);
            if (state == IDLE)
                mem_we <= (state_next == DATA_BUSY) & data_wr;
            else if (state_next == IDLE)
                mem_we <= 1'b0;
            if (!busy)        wait_cnt <= '0;
            else if (!mem_ack) wait_cnt <= wait_cnt + 1'b1;
            fetch_done_raw <= (state == FETCH_BUSY) & finish;
            data_done_q    <= (state == DATA_BUSY) & finish;
            if (timeout) mem_err <= 1'b1;
            if (lpc_acc)               flush_cnt <= 3'(FLUSH_CYCLES);
            else if (flush_cnt != 3'd0) flush_cnt <= flush_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_mem_pipe_sequencer.sv
// Scoreboard bench: each scenario queues per-cycle stimulus with the expected
// output vector, then replays the queue and compares mid-cycle.
module tb_mem_pipe_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic fetch_req, data_req, data_wr, mem_ack, lpc_s3;
    logic mem_req, mem_sel, mem_we, fetch_done, data_done;
    logic hold_s1, hold_s2, hold_s3, flush_s1, flush_s2, mem_err;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic req, sel, we, fd, dd, h1, h2, h3, f1, f2, err;
    } obs_t;

    typedef struct packed {
        logic fr, dr, wr, ack, lpc;
        obs_t exp;
    } ent_t;

    ent_t sb[$];

    mem_pipe_sequencer #(.FLUSH_CYCLES(2), .MAX_WAIT(15), .WAIT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .data_req(data_req),
        .data_wr(data_wr), .mem_ack(mem_ack), .lpc_s3(lpc_s3),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
        .fetch_done(fetch_done), .data_done(data_done),
        .hold_s1(hold_s1), .hold_s2(hold_s2), .hold_s3(hold_s3),
        .flush_s1(flush_s1), .flush_s2(flush_s2), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t ex(input logic req, sel, we, fd, dd, h1, h3, fl, err);
        return {req, sel, we, fd, dd, h1, h3, h3, fl, fl, err};
    endfunction

    function automatic obs_t sample();
        return {mem_req, mem_sel, mem_we, fetch_done, data_done,
                hold_s1, hold_s2, hold_s3, flush_s1, flush_s2, mem_err};
    endfunction

    task automatic push(input logic fr, dr, wr, ack, lpc, input obs_t e);
        sb.push_back({fr, dr, wr, ack, lpc, e});
    endtask

    // Applies one cycle of stimulus and returns outputs observed mid-cycle.
    task automatic drive(input ent_t e, output obs_t o);
        fetch_req = e.fr; data_req = e.dr; data_wr = e.wr;
        mem_ack = e.ack;  lpc_s3 = e.lpc;
        @(negedge clk);
        o = sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        ent_t e;
        int n = 0;
        rst_n = 1'b0;
        fetch_req = 0; data_req = 0; data_wr = 0; mem_ack = 0; lpc_s3 = 0;
        #12;
        checks++;
        if (sample() !== obs_t'(0)) begin
            errors++; $display("FAIL reset_hold got=%b exp=%b", sample(), obs_t'(0));
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL reset_idle c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
    endtask

    task automatic test_single_fetch();
        obs_t o;
        ent_t e;
        int n = 0;
        push(1,0,0,0,0, ex(0,0,0,0,0,1,0,0,0));
        push(1,0,0,0,0, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,0,0, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,1,0, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,0,0, ex(0,0,0,1,0,0,0,0,0));
        push(0,0,0,1,0, ex(0,0,0,0,0,0,0,0,0));   // stray ack while idle
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL single_fetch c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
    endtask

    task automatic test_contention();
        obs_t o;
        ent_t e;
        int n = 0;
        push(1,1,1,0,0, ex(0,0,0,0,0,1,1,0,0));
        push(1,1,1,0,0, ex(1,1,1,0,0,1,1,0,0));
        push(1,1,1,1,0, ex(1,1,1,0,0,1,1,0,0));
        push(1,1,1,0,0, ex(0,0,0,0,1,1,0,0,0));
        push(1,0,0,0,0, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,1,0, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,0,0, ex(0,0,0,1,0,0,0,0,0));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL contention c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
    endtask

    task automatic test_flush();
        obs_t o;
        ent_t e;
        int n = 0;
        push(1,0,0,0,0, ex(0,0,0,0,0,1,0,0,0));
        push(1,0,0,0,1, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,1,0, ex(1,0,0,0,0,1,0,1,0));
        push(1,0,0,0,0, ex(0,0,0,0,0,1,0,1,0));
        push(1,0,0,0,0, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,1,0, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,0,1, ex(0,0,0,0,0,1,0,0,0));   // LPC in the done cycle
        push(1,0,0,0,0, ex(1,0,0,0,0,1,0,1,0));
        push(1,0,0,1,0, ex(1,0,0,0,0,1,0,1,0));
        push(1,0,0,0,0, ex(0,0,0,1,0,0,0,0,0));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL flush c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
    endtask

    task automatic test_held_lpc();
        obs_t o;
        ent_t e;
        int n = 0;
        push(0,1,0,0,1, ex(0,0,0,0,0,1,1,0,0));
        push(0,1,0,0,1, ex(1,1,0,0,0,1,1,0,0));
        push(0,1,0,1,1, ex(1,1,0,0,0,1,1,0,0));
        push(0,1,0,0,1, ex(0,0,0,0,1,0,0,0,0));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,1,0));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,1,0));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL held_lpc c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
    endtask

    task automatic test_ack_at_limit();
        obs_t o;
        ent_t e;
        int n = 0;
        push(0,1,0,0,0, ex(0,0,0,0,0,1,1,0,0));
        for (int i = 1; i <= 14; i++) push(0,1,0,0,0, ex(1,1,0,0,0,1,1,0,0));
        push(0,1,0,1,0, ex(1,1,0,0,0,1,1,0,0));
        push(0,1,0,0,0, ex(0,0,0,0,1,0,0,0,0));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0));
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL ack_at_limit c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        ent_t e;
        int n = 0;
        push(0,1,1,0,0, ex(0,0,0,0,0,1,1,0,0));
        for (int i = 1; i <= 15; i++) push(0,1,1,0,0, ex(1,1,1,0,0,1,1,0,0));
        push(0,1,1,0,0, ex(0,0,0,0,1,0,0,0,1));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,1));
        push(1,0,0,0,0, ex(0,0,0,0,0,1,0,0,1));
        push(1,0,0,1,0, ex(1,0,0,0,0,1,0,0,1));
        push(1,0,0,0,0, ex(0,0,0,1,0,0,0,0,1));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,1));
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL timeout c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
    endtask

    task automatic test_async_reset();
        obs_t o;
        ent_t e;
        int n = 0;
        push(0,1,0,0,0, ex(0,0,0,0,0,1,1,0,1));
        push(0,1,0,0,0, ex(1,1,0,0,0,1,1,0,1));
        push(0,1,0,0,0, ex(1,1,0,0,0,1,1,0,1));
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL pre_reset c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
        fetch_req = 0; data_req = 0; data_wr = 0; mem_ack = 0; lpc_s3 = 0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sample() !== obs_t'(0)) begin
            errors++; $display("FAIL async_reset got=%b exp=%b", sample(), obs_t'(0));
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push(1,0,0,0,0, ex(0,0,0,0,0,1,0,0,0));
        push(1,0,0,1,0, ex(1,0,0,0,0,1,0,0,0));
        push(1,0,0,0,0, ex(0,0,0,1,0,0,0,0,0));
        push(0,0,0,0,0, ex(0,0,0,0,0,0,0,0,0));
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front(); drive(e, o); checks++;
            if (o !== e.exp) begin errors++; $display("FAIL post_reset c%0d got=%b exp=%b", n, o, e.exp); end
            n++;
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_flush();
        test_held_lpc();
        test_ack_at_limit();
        test_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_pipe_sequencer.md
Name: mem_pipe_sequencer

Overview:
Sequences the processor's single-port memory between the fetch stage (stage 1) and the data stage (stage 4: PSH/POP/LDA/STA/call/return), with stage 4 having priority. It generates the pipeline hold signals while an access is outstanding and the stage 1/2 flush window after a PC load from stage 3 (LPC). A watchdog flags memory accesses that never complete. It sits between the stage control generators and the memory interface.

Parameters:
FLUSH_CYCLES, 2, number of cycles flush_s1/flush_s2 stay high after an accepted LPC (1..7)
MAX_WAIT, 15, cycles without mem_ack before an access is abandoned
WAIT_W, 4, width of the wait counter; must hold MAX_WAIT

Ports:
clk  input  1  system-wide clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_req  input  1  stage 1 requests an instruction read; held until fetch_done
data_req  input  1  stage 4 requests a data access; held until data_done
data_wr  input  1  data access is a write; valid with data_req
mem_ack  input  1  memory completes the current access (1-cycle pulse)
lpc_s3  input  1  stage 3 LPC (taken jump/call/return)
mem_req  output  1  access in progress toward memory
mem_sel  output  1  0 = fetch owns the port, 1 = data owns the port
mem_we  output  1  write strobe qualifier (data_wr latched at grant)
fetch_done  output  1  1-cycle pulse: fetch access finished
data_done  output  1  1-cycle pulse: data access finished
hold_s1  output  1  freeze stage 1
hold_s2  output  1  freeze stage 2
hold_s3  output  1  freeze stage 3
flush_s1  output  1  invalidate stage 1 contents
flush_s2  output  1  invalidate stage 2 contents
mem_err  output  1  sticky: an access timed out

Behaviour:
- Reset (async, rst_n=0): state IDLE; every registered output 0 (mem_req, mem_sel, mem_we, both done pulses, both flushes, mem_err); wait and flush counters 0. mem_req drops immediately even mid-access. The interrupted access is lost.
- States: IDLE, FETCH_BUSY, DATA_BUSY.
- IDLE: data_req=1 goes to DATA_BUSY and latches mem_we=data_wr. Otherwise fetch_req=1 goes to FETCH_BUSY. Both requests in the same cycle: data wins; fetch waits. mem_req=1 and mem_sel are set from the next cycle.
- BUSY: mem_req, mem_sel and mem_we are held stable.
- On mem_ack in a BUSY state:
  - Next cycle: the matching done pulses, mem_req=0, state returns to IDLE.
  - A request sampled in that done cycle is granted, so mem_req rises one cycle later. Minimum gap between accesses is one idle cycle.
- Wait counter:
  - Clears on entering BUSY and increments each BUSY cycle with mem_ack=0.
  - At MAX_WAIT: mem_err is set (sticky until reset), the matching done pulses, mem_req drops, state returns to IDLE.
  - mem_ack in the same cycle as the limit counts as success; mem_err is not set.
- mem_ack in IDLE is ignored.
- Hold signals (combinational):
  - hold_s2 = hold_s3 = data_req & ~data_done.
  - hold_s1 = hold_s3 | (fetch_req & ~fetch_done).
- LPC and flush:
  - lpc_s3 is accepted only in a cycle where hold_s3=0.
  - Accepted at cycle t: flush_s1 and flush_s2 are 1 for cycles t+1 .. t+FLUSH_CYCLES.
  - A new accepted LPC during the window reloads the counter to FLUSH_CYCLES.
- Fetch during a flush:
  - An in-flight fetch is never aborted at memory.
  - fetch_done is suppressed (stays 0) if it would pulse while flush_s1=1 or in the cycle lpc_s3 is accepted. The FSM still returns to IDLE.
  - fetch_req, if still high, is then re-served as a new access.
- Data accesses are unaffected by flush.
- No combinational path from mem_ack to any output.

Test Plan:
- Single fetch: fetch_req=1 at c0, mem_ack at c3 -> mem_req=1, mem_sel=0 on c1..c3; fetch_done=1 on c4 only; hold_s1=1 c0..c3, 0 on c4.
- Contention: fetch_req and data_req=1, data_wr=1 at c0, mem_ack at c2 and c5 -> data served first (mem_sel=1, mem_we=1 on c1..c2), data_done c3; fetch mem_req c4..c5, fetch_done c6; hold_s3=1 c0..c2.
- Flush: lpc_s3=1 at c0 with fetch in flight, ack at c1 -> flush_s1/s2=1 on c1..c2; fetch_done not pulsed on c2; fetch re-requested, mem_req rises c3.
- Held LPC: lpc_s3=1 while data access pending (hold_s3=1) -> no flush. Stage 3 stays frozen, so lpc_s3 is still high in the first cycle hold_s3=0; the flush starts the cycle after that.
- Timeout: data_req, no mem_ack, MAX_WAIT=15 -> mem_err=1 and data_done pulse after 15 waiting cycles; mem_err stays 1 through later good accesses.
- Async reset mid-access: rst_n low during DATA_BUSY -> mem_req, mem_sel, mem_err, flushes 0 within the same cycle; after release the FSM is in IDLE and the first request is granted normally.
